// File: rtl/apb_uart_lite_pkg.sv
// Shared register map, bit positions and FSM state types for the APB UART.
package apb_uart_lite_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_BAUD   = 3'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_FRAME_ERR  = 5;
  localparam int ST_TX_BUSY    = 6;

  localparam int CTRL_TX_EN      = 0;
  localparam int CTRL_RX_EN      = 1;
  localparam int CTRL_IRQ_RX     = 2;
  localparam int CTRL_IRQ_TXDONE = 3;

  localparam logic [15:0] BAUD_MIN = 16'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Divisors below the minimum leave no room for a mid-bit RX sample.
  function automatic logic [15:0] clamp_baud(input logic [15:0] v);
    return (v < BAUD_MIN) ? BAUD_MIN : v;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a combinational head so a pop can return its data in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  // Full/empty come from the pre-cycle count, so a push on full is refused even alongside a pop.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_uart_lite.sv
// Zero-wait-state APB3 UART (8N1): TX/RX FIFOs, programmable baud divider, one level interrupt.
module apb_uart_lite
  import apb_uart_lite_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] DEFAULT_DIV    = 16'd867
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      irq_o,
  output logic                      tx_o,
  input  logic                      rx_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic access, wr_acc, rd_acc;
  logic [2:0] reg_sel;
  logic [3:0] ctrl_q;
  logic [15:0] baud_q;
  logic overrun_q, frame_err_q, irq_q;

  tx_state_e tx_state_q;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_shift_q;
  logic tx_q, tx_bit_end, tx_start, tx_busy;

  rx_state_e rx_state_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  logic rx_meta_q, rx_s_q, rx_sample, rx_stop_hit;
  logic rx_set_overrun, rx_set_frame;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic unused_bits;

  assign access   = psel_i & penable_i;
  assign wr_acc   = access & pwrite_i;
  assign rd_acc   = access & ~pwrite_i;
  assign reg_sel  = paddr_i[4:2];
  assign pready_o = 1'b1;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

  assign tx_push    = wr_acc && (reg_sel == REG_DATA);
  assign rx_pop     = rd_acc && (reg_sel == REG_DATA);
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign tx_bit_end = (tx_cnt_q == tx_div_q);
  // A frame launches from IDLE or straight out of the last STOP clock, giving gapless streaming.
  assign tx_start   = ctrl_q[CTRL_TX_EN] & ~tx_empty &
                      ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & tx_bit_end));
  assign tx_pop     = tx_start;

  assign rx_sample      = (rx_cnt_q == '0);
  assign rx_stop_hit    = ctrl_q[CTRL_RX_EN] && (rx_state_q == RX_STOP) && rx_sample;
  assign rx_push        = rx_stop_hit & rx_s_q & ~rx_full;
  assign rx_set_overrun = rx_stop_hit & rx_s_q & rx_full;
  assign rx_set_frame   = rx_stop_hit & ~rx_s_q;

  assign unused_bits = ^{paddr_i[APB_ADDR_WIDTH-1:5], paddr_i[1:0], pwdata_i[31:16], tx_count, rx_count};

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(tx_push), .wdata_i(pwdata_i[7:0]), .pop_i(tx_pop),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push), .wdata_i(rx_shift_q), .pop_i(rx_pop),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  always_comb begin
    prdata_o  = '0;
    pslverr_o = 1'b0;
    if (access) begin
      case (reg_sel)
        REG_DATA: begin
          if (pwrite_i)      pslverr_o = tx_full;
          else if (rx_empty) pslverr_o = 1'b1;
          else               prdata_o  = {24'b0, rx_head};
        end
        REG_STATUS: if (!pwrite_i) prdata_o = {25'b0, tx_busy, frame_err_q, overrun_q,
                                               rx_empty, rx_full, tx_empty, tx_full};
        REG_CTRL:   if (!pwrite_i) prdata_o = {28'b0, ctrl_q};
        REG_BAUD:   if (!pwrite_i) prdata_o = {16'b0, baud_q};
        default:    pslverr_o = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q      <= '0;
      baud_q      <= DEFAULT_DIV;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_acc && reg_sel == REG_CTRL) ctrl_q <= pwdata_i[3:0];
      if (wr_acc && reg_sel == REG_BAUD) baud_q <= clamp_baud(pwdata_i[15:0]);
      // A new error in the same cycle as its W1C wins, so no event is lost.
      if (wr_acc && reg_sel == REG_STATUS && pwdata_i[ST_RX_OVERRUN]) overrun_q <= 1'b0;
      if (wr_acc && reg_sel == REG_STATUS && pwdata_i[ST_FRAME_ERR])  frame_err_q <= 1'b0;
      if (rx_set_overrun) overrun_q   <= 1'b1;
      if (rx_set_frame)   frame_err_q <= 1'b1;
      irq_q <= (ctrl_q[CTRL_IRQ_RX] & (~rx_empty | overrun_q | frame_err_q)) |
               (ctrl_q[CTRL_IRQ_TXDONE] & tx_empty & ~tx_busy);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
      case (tx_state_q)
        TX_IDLE: ;
        TX_START: if (tx_bit_end) begin
          tx_state_q <= TX_DATA;
          tx_cnt_q   <= '0;
          tx_bit_q   <= '0;
          tx_q       <= tx_shift_q[0];
        end
        TX_DATA: if (tx_bit_end) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_q <= TX_STOP;
            tx_q       <= 1'b1;
          end else begin
            tx_bit_q   <= tx_bit_q + 3'd1;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_q       <= tx_shift_q[1];
          end
        end
        TX_STOP: if (tx_bit_end) tx_state_q <= TX_IDLE;
      endcase
      if (tx_start) begin
        tx_state_q <= TX_START;
        tx_q       <= 1'b0;
        tx_cnt_q   <= '0;
        tx_div_q   <= baud_q;
        tx_shift_q <= tx_head;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      if (!ctrl_q[CTRL_RX_EN]) begin
        rx_state_q <= RX_IDLE;
      end else begin
        case (rx_state_q)
          RX_IDLE: if (!rx_s_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= baud_q >> 1;
            rx_div_q   <= baud_q;
          end
          RX_START: begin
            if (!rx_sample) rx_cnt_q <= rx_cnt_q - 16'd1;
            else if (rx_s_q) rx_state_q <= RX_IDLE;
            else begin
              rx_state_q <= RX_DATA;
              rx_cnt_q   <= rx_div_q;
              rx_bit_q   <= '0;
            end
          end
          RX_DATA: begin
            if (!rx_sample) rx_cnt_q <= rx_cnt_q - 16'd1;
            else begin
              rx_shift_q <= {rx_s_q, rx_shift_q[7:1]};
              rx_cnt_q   <= rx_div_q;
              rx_bit_q   <= rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (!rx_sample) rx_cnt_q <= rx_cnt_q - 16'd1;
            else rx_state_q <= RX_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_lite.sv
// Directed bench for apb_uart_lite with a queue-based model of FIFOs, flags and the TX line.
module tb_apb_uart_lite;
  localparam int FD = 8;
  localparam logic [11:0] A_DATA = 12'h000, A_STATUS = 12'h004, A_CTRL = 12'h008, A_BAUD = 12'h00C;

  logic clk = 1'b0, rst = 1'b1;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0, rx = 1'b1;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata;
  logic pready, pslverr, irq, tx;

  int checks = 0, errors = 0;

  logic [7:0] rx_model[$];
  int m_tx_cnt = 0;
  bit m_overrun = 0, m_frame = 0;

  logic exp_wave[$];
  int mon_idx = 0;
  bit mon_armed = 0, mon_done = 0;

  always #5 clk = ~clk;

  apb_uart_lite #(.APB_ADDR_WIDTH(12), .FIFO_DEPTH(FD), .DEFAULT_DIV(16'd867)) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .irq_o(irq), .tx_o(tx), .rx_i(rx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Every cycle from the first start bit, tx_o must follow the precomputed line waveform.
  always @(negedge clk) begin
    if (mon_armed && (mon_idx > 0 || tx === 1'b0)) begin
      if (mon_idx < exp_wave.size()) begin
        check($sformatf("tx_o[%0d]", mon_idx), {31'b0, tx}, {31'b0, exp_wave[mon_idx]});
        mon_idx++;
      end
      if (mon_idx >= exp_wave.size()) begin
        mon_armed = 0;
        mon_done  = 1;
      end
    end
  end

  function automatic logic [31:0] status_exp();
    logic [31:0] s = '0;
    s[0] = (m_tx_cnt == FD);
    s[1] = (m_tx_cnt == 0);
    s[2] = (rx_model.size() == FD);
    s[3] = (rx_model.size() == 0);
    s[4] = m_overrun;
    s[5] = m_frame;
    return s;
  endfunction

  task automatic expect_tx(input logic [7:0] bytes[$], input int div);
    logic [9:0] f;
    exp_wave.delete();
    foreach (bytes[k]) begin
      f = {1'b1, bytes[k], 1'b0};
      for (int b = 0; b < 10; b++)
        for (int c = 0; c <= div; c++) exp_wave.push_back(f[b]);
    end
    for (int c = 0; c < 8; c++) exp_wave.push_back(1'b1);
    mon_idx = 0;
    mon_done = 0;
    mon_armed = 1;
  endtask

  task automatic wait_mon(input string name);
    for (int i = 0; i < 4000 && !mon_done; i++) @(posedge clk);
    check(name, {31'b0, mon_done}, 32'h1);
    mon_armed = 0;
  endtask

  task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    rd = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic wr_reg(input string name, input logic [11:0] addr, input logic [31:0] wd, input bit exp_err);
    logic [31:0] rd; logic err;
    apb(1, addr, wd, rd, err);
    check({name, "_err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic rd_reg(input string name, input logic [11:0] addr, input logic [31:0] exp, input bit exp_err);
    logic [31:0] rd; logic err;
    apb(0, addr, 32'h0, rd, err);
    check(name, rd, exp);
    check({name, "_err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic wr_data(input logic [7:0] b);
    bit full;
    full = (m_tx_cnt == FD);
    wr_reg($sformatf("tx_write_%02h", b), A_DATA, {24'h0, b}, full);
    if (!full) m_tx_cnt++;
  endtask

  task automatic rd_data();
    logic [31:0] exp_d; bit exp_e;
    if (rx_model.size() == 0) begin
      exp_d = 32'h0; exp_e = 1;
    end else begin
      exp_d = {24'h0, rx_model.pop_front()}; exp_e = 0;
    end
    rd_reg("rx_read", A_DATA, exp_d, exp_e);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop, input int bclk);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (bclk) @(posedge clk);
      #1;
    end
    rx = 1;
    repeat (12) @(posedge clk);
    #1;
    if (!stop) m_frame = 1;
    else if (rx_model.size() == FD) m_overrun = 1;
    else rx_model.push_back(b);
  endtask

  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] q[$];
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_tx_o", {31'b0, tx}, 32'h1);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("pready", {31'b0, pready}, 32'h1);
    rd_reg("reset_status", A_STATUS, 32'h0000_000A, 0);
    rd_reg("reset_baud", A_BAUD, 32'd867, 0);
    rd_reg("reset_ctrl", A_CTRL, 32'h0, 0);
    rd_reg("bad_offset_rd", 12'h010, 32'h0, 1);
    wr_reg("bad_offset_wr", 12'h01C, 32'hFFFF_FFFF, 1);
    rd_reg("upper_addr_ignored", 12'h104, 32'h0000_000A, 0);
    wr_reg("baud_wr1", A_BAUD, 32'h1, 0);
    rd_reg("baud_clamp", A_BAUD, 32'd3, 0);

    // single 0xA5 frame at 4 clocks/bit
    wr_reg("ctrl_tx", A_CTRL, 32'h1, 0);
    q.delete(); q.push_back(8'hA5);
    expect_tx(q, 3);
    wr_reg("tx_a5", A_DATA, 32'hA5, 0);
    wait_mon("tx_a5_frame");
    rd_reg("tx_idle_after_frame", A_STATUS, 32'h0000_000A, 0);

    // fill the TX FIFO with transmit disabled, then stream
    wr_reg("ctrl_off", A_CTRL, 32'h0, 0);
    for (int i = 0; i < 9; i++) wr_data(8'h30 + 8'(i));
    rd_reg("status_tx_full", A_STATUS, 32'h0000_0009, 0);
    rd_reg("status_tx_full_model", A_STATUS, status_exp(), 0);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'h30 + 8'(i));
    expect_tx(q, 3);
    wr_reg("ctrl_tx_on", A_CTRL, 32'h1, 0);
    wait_mon("tx_burst_frames");
    m_tx_cnt = 0;
    wr_reg("ctrl_txdone", A_CTRL, 32'h9, 0);
    repeat (2) @(negedge clk);
    check("irq_txdone", {31'b0, irq}, 32'h1);
    rd_reg("status_tx_drained", A_STATUS, status_exp(), 0);

    // RX single byte at 8 clocks/bit
    wr_reg("baud_7", A_BAUD, 32'd7, 0);
    wr_reg("ctrl_rx", A_CTRL, 32'h6, 0);
    repeat (2) @(negedge clk);
    check("irq_rx_idle", {31'b0, irq}, 32'h0);
    send_rx(8'h3C, 1, 8);
    @(negedge clk);
    check("irq_rx", {31'b0, irq}, 32'h1);
    rd_reg("rx_3c", A_DATA, 32'h0000_003C, 0);
    void'(rx_model.pop_front());
    rd_data();
    repeat (2) @(negedge clk);
    check("irq_rx_cleared", {31'b0, irq}, 32'h0);

    // start-bit glitch, then a framing error and its W1C
    @(posedge clk); #1 rx = 0;
    repeat (2) @(posedge clk);
    #1 rx = 1;
    repeat (12) @(posedge clk);
    rd_reg("glitch_status", A_STATUS, 32'h0000_000A, 0);
    send_rx(8'h55, 0, 8);
    rd_reg("frame_err_status", A_STATUS, 32'h0000_002A, 0);
    @(negedge clk);
    check("irq_frame_err", {31'b0, irq}, 32'h1);
    wr_reg("w1c_frame", A_STATUS, 32'h20, 0);
    m_frame = 0;
    rd_reg("frame_err_cleared", A_STATUS, status_exp(), 0);

    // overflow the RX FIFO
    for (int i = 0; i < 9; i++) send_rx(8'(i * 37 + 5), 1, 8);
    rd_reg("status_rx_overrun", A_STATUS, status_exp(), 0);
    rd_reg("status_rx_overrun_lit", A_STATUS, 32'h0000_0016, 0);
    for (int i = 0; i < 9; i++) rd_data();
    rd_reg("status_overrun_kept", A_STATUS, status_exp(), 0);
    wr_reg("w1c_overrun", A_STATUS, 32'h10, 0);
    m_overrun = 0;
    rd_reg("overrun_cleared", A_STATUS, status_exp(), 0);

    // reset in the middle of a TX frame
    wr_reg("ctrl_tx2", A_CTRL, 32'h1, 0);
    wr_reg("tx_00", A_DATA, 32'h0, 0);
    for (int i = 0; i < 200 && tx !== 1'b0; i++) @(negedge clk);
    check("tx_started", {31'b0, tx}, 32'h0);
    repeat (10) @(negedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("tx_after_rst", {31'b0, tx}, 32'h1);
    @(posedge clk); #1 rst = 0;
    rx_model.delete(); m_tx_cnt = 0; m_overrun = 0; m_frame = 0;
    repeat (20) @(negedge clk);
    check("tx_idle_after_rst", {31'b0, tx}, 32'h1);
    check("irq_after_rst", {31'b0, irq}, 32'h0);
    rd_reg("status_after_rst", A_STATUS, status_exp(), 0);
    rd_reg("ctrl_after_rst", A_CTRL, 32'h0, 0);
    rd_reg("baud_after_rst", A_BAUD, 32'd867, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
